// File: rtl/up_down_count_ctrl_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : up_down_count_ctrl_if
// Brief  : Command/status bundle between system control and the count sequencer.
// Rev    : 1.0
//------------------------------------------------------------------------------
interface up_down_count_ctrl_if #(
    parameter int WIDTH = 3
);
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             pause;
    logic             stop;
    logic [WIDTH-1:0] q;
    logic             ud;
    logic             busy;
    logic             tc;
    logic             done;
    logic             err;

    modport master (
        output start, mode, lo, hi, pause, stop,
        input  q, ud, busy, tc, done, err
    );

    modport slave (
        input  start, mode, lo, hi, pause, stop,
        output q, ud, busy, tc, done, err
    );
endinterface
`default_nettype wire

// File: rtl/up_down_count_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : up_down_count_ctrl
// Brief  : Sequencer stepping a registered up/down count over [lo,hi] per mode.
// Rev    : 1.0
//------------------------------------------------------------------------------
module up_down_count_ctrl #(
    parameter int WIDTH = 3
) (
    input  wire logic           clk,
    input  wire logic           clear,
    up_down_count_ctrl_if.slave bus
);
    localparam logic [1:0] c_MODE_UP_ONCE   = 2'b00;
    localparam logic [1:0] c_MODE_DOWN_ONCE = 2'b01;
    localparam logic [1:0] c_MODE_BOUNCE    = 2'b10;
    localparam logic [1:0] c_MODE_WRAP_UP   = 2'b11;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] w_lo_nxt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [1:0]       r_mode;
    logic [1:0]       w_mode_nxt;
    logic             r_ud;
    logic             w_ud_nxt;
    logic             r_tc;
    logic             w_tc_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_err;
    logic             w_err_nxt;

    logic [WIDTH-1:0] w_end;
    logic             w_at_end;
    logic [WIDTH-1:0] w_q_inc;
    logic [WIDTH-1:0] w_q_dec;

    assign w_end    = r_ud ? r_hi : r_lo;
    assign w_at_end = (r_q == w_end);
    assign w_q_inc  = r_q + WIDTH'(1);
    assign w_q_dec  = r_q - WIDTH'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_ud_nxt    = r_ud;
        w_lo_nxt    = r_lo;
        w_hi_nxt    = r_hi;
        w_mode_nxt  = r_mode;
        w_tc_nxt    = r_tc;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_tc_nxt = 1'b0;
                if (bus.start) begin
                    if (bus.lo <= bus.hi) begin
                        w_state_nxt = S_RUN;
                        w_lo_nxt    = bus.lo;
                        w_hi_nxt    = bus.hi;
                        w_mode_nxt  = bus.mode;
                        // Entry point is the start of the range in travel direction.
                        if (bus.mode == c_MODE_DOWN_ONCE) begin
                            w_q_nxt  = bus.hi;
                            w_ud_nxt = 1'b0;
                        end else begin
                            w_q_nxt  = bus.lo;
                            w_ud_nxt = 1'b1;
                        end
                        w_tc_nxt = (bus.lo == bus.hi);
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end

            S_RUN: begin
                if (bus.stop) begin
                    w_state_nxt = S_IDLE;
                    w_tc_nxt    = 1'b0;
                end else if (!bus.pause) begin
                    case (r_mode)
                        c_MODE_UP_ONCE, c_MODE_DOWN_ONCE: begin
                            if (w_at_end) begin
                                w_state_nxt = S_IDLE;
                                w_done_nxt  = 1'b1;
                            end else begin
                                w_q_nxt = r_ud ? w_q_inc : w_q_dec;
                            end
                        end
                        c_MODE_BOUNCE: begin
                            if (!w_at_end) begin
                                w_q_nxt = r_ud ? w_q_inc : w_q_dec;
                            end else if (r_lo != r_hi) begin
                                // Turn around and leave the endpoint on the same edge.
                                w_ud_nxt = ~r_ud;
                                w_q_nxt  = r_ud ? w_q_dec : w_q_inc;
                            end
                        end
                        c_MODE_WRAP_UP: begin
                            w_q_nxt = (r_q == r_hi) ? r_lo : w_q_inc;
                        end
                        default: begin
                            w_q_nxt = r_q;
                        end
                    endcase

                    // tc is registered, so it reflects the position being entered.
                    if (w_state_nxt == S_RUN) begin
                        w_tc_nxt = (w_q_nxt == (w_ud_nxt ? r_hi : r_lo));
                    end else begin
                        w_tc_nxt = 1'b0;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_tc_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_ud    <= 1'b1;
            r_lo    <= '0;
            r_hi    <= '0;
            r_mode  <= 2'b00;
            r_tc    <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_ud    <= w_ud_nxt;
            r_lo    <= w_lo_nxt;
            r_hi    <= w_hi_nxt;
            r_mode  <= w_mode_nxt;
            r_tc    <= w_tc_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign bus.q    = r_q;
    assign bus.ud   = r_ud;
    assign bus.busy = (r_state == S_RUN);
    assign bus.tc   = r_tc;
    assign bus.done = r_done;
    assign bus.err  = r_err;
endmodule
`default_nettype wire

// File: tb/tb_up_down_count_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_up_down_count_ctrl
// Brief  : Directed scenarios plus randomized run against a step-index model.
// Rev    : 1.0
//------------------------------------------------------------------------------
module tb_up_down_count_ctrl;
    logic clk;
    logic clear;
    int   n_checks;
    int   n_errors;

    up_down_count_ctrl_if #(.WIDTH(3)) bus ();

    up_down_count_ctrl #(.WIDTH(3)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: position derived from the number of steps taken (m_k).
    bit m_run;
    int m_k;
    int m_lo;
    int m_hi;
    int m_mode;
    int m_q;
    bit m_ud;
    bit m_tc;
    bit m_done;
    bit m_err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0;
        bus.pause = 1'b0;
        bus.stop  = 1'b0;
    endtask

    task automatic start_cmd(input int md, input int lo, input int hi);
        bus.mode  = 2'(md);
        bus.lo    = 3'(lo);
        bus.hi    = 3'(hi);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic model_position();
        int n;
        int r;
        n = m_hi - m_lo;
        case (m_mode)
            0: begin m_q = m_lo + m_k; m_ud = 1'b1; m_tc = (m_k == n); end
            1: begin m_q = m_hi - m_k; m_ud = 1'b0; m_tc = (m_k == n); end
            2: begin
                if (n == 0) begin
                    m_q = m_lo; m_ud = 1'b1; m_tc = 1'b1;
                end else begin
                    r    = m_k % (2 * n);
                    m_q  = (r <= n) ? m_lo + r : m_hi - (r - n);
                    m_ud = (m_k == 0) ? 1'b1 : (r == 0) ? 1'b0 : (r <= n);
                    m_tc = (r == n) || (r == 0 && m_k > 0);
                end
            end
            default: begin
                m_q = m_lo + (m_k % (n + 1)); m_ud = 1'b1; m_tc = (m_q == m_hi);
            end
        endcase
    endtask

    task automatic model_edge(input bit clr_n, input bit st, input int md,
                              input int lo, input int hi, input bit ps, input bit sp);
        m_done = 1'b0;
        m_err  = 1'b0;
        if (!clr_n) begin
            m_run = 1'b0; m_q = 0; m_ud = 1'b1; m_tc = 1'b0;
            m_lo = 0; m_hi = 0; m_mode = 0; m_k = 0;
        end else if (!m_run) begin
            m_tc = 1'b0;
            if (st) begin
                if (lo <= hi) begin
                    m_run = 1'b1; m_k = 0; m_lo = lo; m_hi = hi; m_mode = md;
                    model_position();
                end else begin
                    m_err = 1'b1;
                end
            end
        end else if (sp) begin
            m_run = 1'b0;
            m_tc  = 1'b0;
        end else if (!ps) begin
            m_k++;
            if (m_mode < 2 && m_k > m_hi - m_lo) begin
                m_run = 1'b0; m_tc = 1'b0; m_done = 1'b1;
            end else begin
                model_position();
            end
        end
    endtask

    task automatic test_reset();
        clear = 1'b0;
        idle_inputs();
        bus.mode = 2'b00; bus.lo = 3'd0; bus.hi = 3'd0;
        tick();
        tick();
        n_checks += 6;
        if (bus.q    !== 3'd0) begin n_errors++; $display("FAIL reset_q got=%0d exp=0", bus.q); end
        if (bus.ud   !== 1'b1) begin n_errors++; $display("FAIL reset_ud got=%b exp=1", bus.ud); end
        if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        if (bus.tc   !== 1'b0) begin n_errors++; $display("FAIL reset_tc got=%b exp=0", bus.tc); end
        if (bus.done !== 1'b0) begin n_errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        if (bus.err  !== 1'b0) begin n_errors++; $display("FAIL reset_err got=%b exp=0", bus.err); end
        clear = 1'b1;
        tick();
    endtask

    task automatic test_up_once();
        start_cmd(0, 2, 5);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            n_checks += 3;
            if (bus.q !== 3'(2 + i)) begin n_errors++; $display("FAIL up_q[%0d] got=%0d exp=%0d", i, bus.q, 2 + i); end
            if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL up_busy[%0d] got=%b exp=1", i, bus.busy); end
            if (bus.tc !== (i == 3)) begin n_errors++; $display("FAIL up_tc[%0d] got=%b exp=%b", i, bus.tc, i == 3); end
        end
        tick();
        n_checks += 3;
        if (bus.done !== 1'b1) begin n_errors++; $display("FAIL up_done got=%b exp=1", bus.done); end
        if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL up_end_busy got=%b exp=0", bus.busy); end
        if (bus.q !== 3'd5) begin n_errors++; $display("FAIL up_end_q got=%0d exp=5", bus.q); end
        tick();
        n_checks++;
        if (bus.done !== 1'b0) begin n_errors++; $display("FAIL up_done_pulse got=%b exp=0", bus.done); end
    endtask

    task automatic test_down_once();
        start_cmd(1, 1, 4);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            n_checks += 3;
            if (bus.q !== 3'(4 - i)) begin n_errors++; $display("FAIL dn_q[%0d] got=%0d exp=%0d", i, bus.q, 4 - i); end
            if (bus.ud !== 1'b0) begin n_errors++; $display("FAIL dn_ud[%0d] got=%b exp=0", i, bus.ud); end
            if (bus.err !== 1'b0) begin n_errors++; $display("FAIL dn_err[%0d] got=%b exp=0", i, bus.err); end
        end
        tick();
        n_checks += 3;
        if (bus.done !== 1'b1) begin n_errors++; $display("FAIL dn_done got=%b exp=1", bus.done); end
        if (bus.q !== 3'd1) begin n_errors++; $display("FAIL dn_end_q got=%0d exp=1", bus.q); end
        if (bus.err !== 1'b0) begin n_errors++; $display("FAIL dn_end_err got=%b exp=0", bus.err); end
        tick();
    endtask

    task automatic test_bounce_clear();
        int eq[8]  = '{1, 2, 3, 2, 1, 2, 3, 2};
        bit eud[8] = '{1, 1, 1, 0, 0, 1, 1, 0};
        start_cmd(2, 1, 3);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            // A start with a bad range mid-run must be ignored.
            bus.start = (i == 2);
            bus.lo = 3'd6; bus.hi = 3'd2; bus.mode = 2'b01;
            n_checks += 3;
            if (bus.q !== 3'(eq[i])) begin n_errors++; $display("FAIL bnc_q[%0d] got=%0d exp=%0d", i, bus.q, eq[i]); end
            if (bus.ud !== eud[i]) begin n_errors++; $display("FAIL bnc_ud[%0d] got=%b exp=%b", i, bus.ud, eud[i]); end
            if (bus.err !== 1'b0) begin n_errors++; $display("FAIL bnc_err[%0d] got=%b exp=0", i, bus.err); end
        end
        // q=2 going down: clear wins over a simultaneous valid start.
        clear = 1'b0;
        start_cmd(1, 3, 5);
        clear = 1'b1;
        n_checks += 4;
        if (bus.q !== 3'd0) begin n_errors++; $display("FAIL clr_q got=%0d exp=0", bus.q); end
        if (bus.ud !== 1'b1) begin n_errors++; $display("FAIL clr_ud got=%b exp=1", bus.ud); end
        if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL clr_busy got=%b exp=0", bus.busy); end
        if (bus.tc !== 1'b0) begin n_errors++; $display("FAIL clr_tc got=%b exp=0", bus.tc); end
        tick();
        n_checks++;
        if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL clr_after_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_wrap_pause();
        int eq[12] = '{0, 1, 2, 3, 4, 4, 4, 4, 5, 6, 7, 0};
        start_cmd(3, 0, 7);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) tick();
            bus.pause = (i >= 4 && i <= 6);
            n_checks += 3;
            if (bus.q !== 3'(eq[i])) begin n_errors++; $display("FAIL wrap_q[%0d] got=%0d exp=%0d", i, bus.q, eq[i]); end
            if (bus.ud !== 1'b1) begin n_errors++; $display("FAIL wrap_ud[%0d] got=%b exp=1", i, bus.ud); end
            if (bus.tc !== (eq[i] == 7)) begin n_errors++; $display("FAIL wrap_tc[%0d] got=%b exp=%b", i, bus.tc, eq[i] == 7); end
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        n_checks += 2;
        if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL wrap_stop_busy got=%b exp=0", bus.busy); end
        if (bus.q !== 3'd0) begin n_errors++; $display("FAIL wrap_stop_q got=%0d exp=0", bus.q); end
    endtask

    task automatic test_err_stop();
        start_cmd(0, 6, 2);
        n_checks += 3;
        if (bus.err !== 1'b1) begin n_errors++; $display("FAIL err_pulse got=%b exp=1", bus.err); end
        if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL err_busy got=%b exp=0", bus.busy); end
        if (bus.q !== 3'd0) begin n_errors++; $display("FAIL err_q got=%0d exp=0", bus.q); end
        tick();
        n_checks++;
        if (bus.err !== 1'b0) begin n_errors++; $display("FAIL err_one_cycle got=%b exp=0", bus.err); end
        start_cmd(0, 0, 6);
        tick(); tick(); tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        n_checks += 3;
        if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL stop_busy got=%b exp=0", bus.busy); end
        if (bus.q !== 3'd3) begin n_errors++; $display("FAIL stop_q got=%0d exp=3", bus.q); end
        if (bus.done !== 1'b0) begin n_errors++; $display("FAIL stop_done got=%b exp=0", bus.done); end
        tick();
        n_checks++;
        if (bus.done !== 1'b0) begin n_errors++; $display("FAIL stop_done_late got=%b exp=0", bus.done); end
    endtask

    task automatic test_lo_eq_hi();
        start_cmd(0, 4, 4);
        n_checks += 3;
        if (bus.q !== 3'd4) begin n_errors++; $display("FAIL eq_once_q got=%0d exp=4", bus.q); end
        if (bus.tc !== 1'b1) begin n_errors++; $display("FAIL eq_once_tc got=%b exp=1", bus.tc); end
        if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL eq_once_busy got=%b exp=1", bus.busy); end
        tick();
        n_checks += 2;
        if (bus.done !== 1'b1) begin n_errors++; $display("FAIL eq_once_done got=%b exp=1", bus.done); end
        if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL eq_once_idle got=%b exp=0", bus.busy); end
        start_cmd(2, 2, 2);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            n_checks += 3;
            if (bus.q !== 3'd2) begin n_errors++; $display("FAIL eq_bnc_q[%0d] got=%0d exp=2", i, bus.q); end
            if (bus.tc !== 1'b1) begin n_errors++; $display("FAIL eq_bnc_tc[%0d] got=%b exp=1", i, bus.tc); end
            if (bus.ud !== 1'b1) begin n_errors++; $display("FAIL eq_bnc_ud[%0d] got=%b exp=1", i, bus.ud); end
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
    endtask

    task automatic test_random();
        bit c;
        bit s;
        bit p;
        bit t;
        int md;
        int lo;
        int hi;
        for (int i = 0; i < 1500; i++) begin
            c  = (i != 0) && ($urandom_range(0, 59) != 0);
            s  = ($urandom_range(0, 3) == 0);
            p  = ($urandom_range(0, 5) == 0);
            t  = ($urandom_range(0, 29) == 0);
            md = int'($urandom_range(0, 3));
            lo = int'($urandom_range(0, 7));
            hi = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(lo, 7));
            clear     = c;
            bus.start = s;
            bus.pause = p;
            bus.stop  = t;
            bus.mode  = 2'(md);
            bus.lo    = 3'(lo);
            bus.hi    = 3'(hi);
            model_edge(c, s, md, lo, hi, p, t);
            tick();
            n_checks += 6;
            if (bus.q !== 3'(m_q)) begin n_errors++; $display("FAIL rnd_q[%0d] got=%0d exp=%0d", i, bus.q, m_q); end
            if (bus.ud !== m_ud) begin n_errors++; $display("FAIL rnd_ud[%0d] got=%b exp=%b", i, bus.ud, m_ud); end
            if (bus.busy !== m_run) begin n_errors++; $display("FAIL rnd_busy[%0d] got=%b exp=%b", i, bus.busy, m_run); end
            if (bus.tc !== m_tc) begin n_errors++; $display("FAIL rnd_tc[%0d] got=%b exp=%b", i, bus.tc, m_tc); end
            if (bus.done !== m_done) begin n_errors++; $display("FAIL rnd_done[%0d] got=%b exp=%b", i, bus.done, m_done); end
            if (bus.err !== m_err) begin n_errors++; $display("FAIL rnd_err[%0d] got=%b exp=%b", i, bus.err, m_err); end
        end
        clear = 1'b1;
        idle_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clear    = 1'b0;
        idle_inputs();
        test_reset();
        test_up_once();
        test_down_once();
        test_bounce_clear();
        test_wrap_pause();
        test_err_stop();
        test_lo_eq_hi();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
